// File: rtl/event_seq_pkg.sv
`default_nettype none
// ============================================================================
// event_seq_pkg : shared types/constants for the ordered-event generator
// Rev 1.0
// ============================================================================
package event_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    FIRE  = 3'd2,
    ACKW  = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam int NUM_EV = 3;
  localparam logic [1:0] LAST_IDX = 2'(NUM_EV - 1);

endpackage
`default_nettype wire

// File: rtl/event_seq_gen_cnt.sv
`default_nettype none
// ============================================================================
// ld_down_cnt : loadable down-counter that parks at zero, with a zero flag
// Rev 1.0
// ============================================================================
module ld_down_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/event_seq_gen.sv
`default_nettype none
// ============================================================================
// event_seq_gen : emits e1/e2/e3 in order with programmable gaps and an
//                 optional per-pulse ack handshake with timeout
// Rev 1.0
// ============================================================================
module event_seq_gen
  import event_seq_pkg::*;
#(
  parameter int DLY_W  = 8,
  parameter int TO_W   = 8,
  parameter bit ACK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DLY_W-1:0] gap1,
  input  logic [DLY_W-1:0] gap2,
  input  logic [DLY_W-1:0] gap3,
  input  logic [TO_W-1:0]  timeout,
  input  logic             ack,
  output logic             e1,
  output logic             e2,
  output logic             e3,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       ev_cnt,
  output logic [3:0]       seq_id
);

  seq_state_t       r_state, w_nxt;
  logic [DLY_W-1:0] r_gap2, r_gap3, w_gap_sel;
  logic [TO_W-1:0]  r_to;
  logic [1:0]       r_idx, w_nidx;
  logic             w_fire, w_adv, w_start_acc, w_dly_ld, w_to_ld, w_to_exp;
  logic             w_dly_zero, w_to_zero;

  // A gap of g costs g DELAY cycles, so the counter is loaded with g-1 and
  // a zero gap skips DELAY entirely.
  ld_down_cnt #(.W(DLY_W)) u_dly_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_dly_ld),
    .load_val (w_gap_sel - DLY_W'(1)),
    .dec      (r_state == DELAY),
    .zero     (w_dly_zero)
  );

  ld_down_cnt #(.W(TO_W)) u_to_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_to_ld),
    .load_val (r_to - TO_W'(1)),
    .dec      (r_state == ACKW),
    .zero     (w_to_zero)
  );

  always_comb begin
    w_nxt       = r_state;
    w_fire      = 1'b0;
    w_adv       = 1'b0;
    w_start_acc = 1'b0;
    w_to_ld     = 1'b0;
    w_to_exp    = 1'b0;

    // Index of the pulse being scheduled next, and the gap preceding it
    case (r_state)
      IDLE: begin
        w_nidx    = 2'd0;
        w_gap_sel = gap1;
      end
      DELAY: begin
        w_nidx    = r_idx;
        w_gap_sel = '0;
      end
      default: begin
        w_nidx    = r_idx + 2'd1;
        w_gap_sel = (r_idx == 2'd0) ? r_gap2 : r_gap3;
      end
    endcase

    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_adv       = 1'b1;
        end
      end
      DELAY: begin
        if (w_dly_zero) begin
          w_nxt  = FIRE;
          w_fire = 1'b1;
        end
      end
      FIRE: begin
        if (ACK_EN) begin
          w_nxt   = ACKW;
          w_to_ld = 1'b1;
        end else if (r_idx == LAST_IDX) begin
          w_nxt = DONE;
        end else begin
          w_adv = 1'b1;
        end
      end
      ACKW: begin
        if (ack) begin
          if (r_idx == LAST_IDX) w_nxt = DONE;
          else                   w_adv = 1'b1;
        end else if ((r_to != '0) && w_to_zero) begin
          w_nxt    = DONE;
          w_to_exp = 1'b1;
        end
      end
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase

    if (w_adv) begin
      if (w_gap_sel == '0) begin
        w_nxt  = FIRE;
        w_fire = 1'b1;
      end else begin
        w_nxt = DELAY;
      end
    end
    w_dly_ld = w_adv && (w_gap_sel != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gap2  <= '0;
      r_gap3  <= '0;
      r_to    <= '0;
      r_idx   <= '0;
      e1      <= 1'b0;
      e2      <= 1'b0;
      e3      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      ev_cnt  <= '0;
      seq_id  <= '0;
    end else begin
      r_state <= w_nxt;
      busy    <= (w_nxt != IDLE);
      done    <= (w_nxt == DONE);
      e1      <= w_fire && (w_nidx == 2'd0);
      e2      <= w_fire && (w_nidx == 2'd1);
      e3      <= w_fire && (w_nidx == 2'd2);

      if (w_adv) r_idx <= w_nidx;

      if (w_start_acc) begin
        r_gap2 <= gap2;
        r_gap3 <= gap3;
        r_to   <= timeout;
        err    <= 1'b0;
      end

      // A zero gap1 fires e1 in the same edge that accepts start
      if (w_fire)           ev_cnt <= (r_state == IDLE) ? 2'd1 : ev_cnt + 2'd1;
      else if (w_start_acc) ev_cnt <= '0;

      if (w_to_exp) err <= 1'b1;

      if ((w_nxt == DONE) && (r_state != DONE) && !w_to_exp)
        seq_id <= seq_id + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_event_seq_gen.sv
`default_nettype none
// ============================================================================
// tb_event_seq_gen : directed scoreboard bench for event_seq_gen
// Rev 1.0
// ============================================================================
module tb_event_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, ack = 1'b0;
  logic [7:0] gap1 = '0, gap2 = '0, gap3 = '0, timeout = '0;

  logic       e1_a, e2_a, e3_a, busy_a, done_a, err_a;
  logic [1:0] ev_cnt_a;
  logic [3:0] seq_id_a;
  logic       e1_b, e2_b, e3_b, busy_b, done_b, err_b;
  logic [1:0] ev_cnt_b;
  logic [3:0] seq_id_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int kind;   // 1..3 = e1..e3, 4 = done
    int at;
    int er;
  } ev_t;
  ev_t q_a[$];
  ev_t q_b[$];

  event_seq_gen #(.DLY_W(8), .TO_W(8), .ACK_EN(1'b0)) u_free (
    .clk(clk), .rst(rst), .start(start_a), .gap1(gap1), .gap2(gap2), .gap3(gap3),
    .timeout(timeout), .ack(ack), .e1(e1_a), .e2(e2_a), .e3(e3_a), .busy(busy_a),
    .done(done_a), .err(err_a), .ev_cnt(ev_cnt_a), .seq_id(seq_id_a)
  );

  event_seq_gen #(.DLY_W(8), .TO_W(8), .ACK_EN(1'b1)) u_ack (
    .clk(clk), .rst(rst), .start(start_b), .gap1(gap1), .gap2(gap2), .gap3(gap3),
    .timeout(timeout), .ack(ack), .e1(e1_b), .e2(e2_b), .e3(e3_b), .busy(busy_b),
    .done(done_b), .err(err_b), .ev_cnt(ev_cnt_b), .seq_id(seq_id_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic push(input int d, input int kind, input int at, input int er);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.er   = er;
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  // Pops the next expected event for DUT d and compares it with what fired
  task automatic observe(input int d, input int kind, input int er);
    ev_t   e;
    string nm;
    nm = (d == 0) ? "free" : "ack";
    if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
      chk($sformatf("%s_unexpected_kind%0d_at%0d", nm, kind, cyc), kind, 0);
      return;
    end
    if (d == 0) e = q_a.pop_front();
    else        e = q_b.pop_front();
    chk($sformatf("%s_kind", nm), kind, e.kind);
    chk($sformatf("%s_kind%0d_cycle", nm, e.kind), cyc, e.at);
    if (kind == 4) chk($sformatf("%s_done_err", nm), er, e.er);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (e1_a)   observe(0, 1, 0);
      if (e2_a)   observe(0, 2, 0);
      if (e3_a)   observe(0, 3, 0);
      if (done_a) observe(0, 4, int'(err_a));
      if (e1_b)   observe(1, 1, 0);
      if (e2_b)   observe(1, 2, 0);
      if (e3_b)   observe(1, 3, 0);
      if (done_b) observe(1, 4, int'(err_b));
    end
  end

  task automatic t1_run(input int exp_seq);
    int s;
    gap1 = 8'd10; gap2 = 8'd20; gap3 = 8'd30;
    s = cyc;
    push(0, 1, s + 11, 0); push(0, 2, s + 32, 0);
    push(0, 3, s + 63, 0); push(0, 4, s + 64, 0);
    start_a = 1'b1; step(); start_a = 1'b0;
    chk("t1_busy_rise", busy_a, 1);
    wait_until(s + 66);
    chk("t1_ev_cnt", ev_cnt_a, 3);
    chk("t1_seq_id", seq_id_a, exp_seq);
    chk("t1_busy_low", busy_a, 0);
    chk("t1_err", err_a, 0);
    chk("t1_pending", q_a.size(), 0);
  endtask

  initial begin
    int s;

    // Reset state
    repeat (3) step();
    chk("rst_free", {e1_a, e2_a, e3_a, done_a, busy_a, err_a, ev_cnt_a, seq_id_a}, 0);
    chk("rst_ack",  {e1_b, e2_b, e3_b, done_b, busy_b, err_b, ev_cnt_b, seq_id_b}, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Free-running, gaps 10/20/30
    t1_run(1);

    // Free-running, zero gaps; restart while busy ignored; restart after done
    gap1 = '0; gap2 = '0; gap3 = '0;
    s = cyc;
    push(0, 1, s + 1, 0); push(0, 2, s + 2, 0); push(0, 3, s + 3, 0); push(0, 4, s + 4, 0);
    push(0, 1, s + 6, 0); push(0, 2, s + 7, 0); push(0, 3, s + 8, 0); push(0, 4, s + 9, 0);
    start_a = 1'b1; step(); start_a = 1'b0;
    chk("t2_busy_rise", busy_a, 1);
    wait_until(s + 2);
    start_a = 1'b1; step(); start_a = 1'b0;
    wait_until(s + 5);
    chk("t2_busy_fall", busy_a, 0);
    start_a = 1'b1; step(); start_a = 1'b0;
    wait_until(s + 11);
    chk("t2_seq_id", seq_id_a, 3);
    chk("t2_ev_cnt", ev_cnt_a, 3);

    // Handshake with timeout 5, e3 ack withheld
    gap1 = 8'd2; gap2 = 8'd2; gap3 = 8'd2; timeout = 8'd5;
    s = cyc;
    push(1, 1, s + 3, 0); push(1, 2, s + 8, 0); push(1, 4, s + 14, 1);
    start_b = 1'b1; step(); start_b = 1'b0;
    wait_until(s + 5);
    ack = 1'b1; step(); ack = 1'b0;
    wait_until(s + 16);
    chk("t3_err", err_b, 1);
    chk("t3_ev_cnt", ev_cnt_b, 2);
    chk("t3_seq_id", seq_id_b, 0);
    chk("t3_busy", busy_b, 0);
    chk("t3_pending", q_b.size(), 0);

    // Handshake with infinite window, long stall before first ack
    gap1 = 8'd1; gap2 = 8'd1; gap3 = 8'd1; timeout = '0;
    s = cyc;
    push(1, 1, s + 2, 0); push(1, 2, s + 104, 0); push(1, 3, s + 108, 0); push(1, 4, s + 110, 0);
    start_b = 1'b1; step(); start_b = 1'b0;
    wait_until(s + 50);
    chk("t4_stall_busy", busy_b, 1);
    chk("t4_stall_err", err_b, 0);
    wait_until(s + 102); ack = 1'b1; step(); ack = 1'b0;
    wait_until(s + 106); ack = 1'b1; step(); ack = 1'b0;
    wait_until(s + 109); ack = 1'b1; step(); ack = 1'b0;
    wait_until(s + 112);
    chk("t4_seq_id", seq_id_b, 1);
    chk("t4_err", err_b, 0);
    chk("t4_ev_cnt", ev_cnt_b, 3);

    // Reset mid-DELAY between e1 and e2
    gap1 = 8'd10; gap2 = 8'd20; gap3 = 8'd30;
    s = cyc;
    push(0, 1, s + 11, 0);
    start_a = 1'b1; step(); start_a = 1'b0;
    wait_until(s + 20);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_free_cleared", {e1_a, e2_a, e3_a, done_a, busy_a, err_a, ev_cnt_a, seq_id_a}, 0);
    chk("t5_ack_seq_id", seq_id_b, 0);
    wait_until(s + 120);
    chk("t5_pending", q_a.size(), 0);
    t1_run(1);

    // 16 back-to-back handshake runs; ack in IDLE and FIRE cycles ignored
    gap1 = '0; gap2 = '0; gap3 = '0; timeout = 8'd3;
    for (int k = 0; k < 16; k++) begin
      s = cyc;
      push(1, 1, s + 1, 0); push(1, 2, s + 4, 0); push(1, 3, s + 6, 0); push(1, 4, s + 8, 0);
      start_b = 1'b1; ack = 1'b1; step();
      start_b = 1'b0; step();
      ack = 1'b0;
      wait_until(s + 3); ack = 1'b1; step(); ack = 1'b0;
      wait_until(s + 5); ack = 1'b1; step(); ack = 1'b0;
      wait_until(s + 7); ack = 1'b1; step(); ack = 1'b0;
      wait_until(s + 9);
      chk($sformatf("t6_seq_id_run%0d", k), seq_id_b, (k + 1) % 16);
    end

    step();
    chk("end_pending_free", q_a.size(), 0);
    chk("end_pending_ack", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
